// File: rtl/lif_pkg.sv
// Shared defaults and saturating helpers for the leaky-integrate-and-fire network.
package lif_pkg;

  localparam int unsigned DefInW       = 8;
  localparam int unsigned DefW         = 8;
  localparam int unsigned DefWtW       = 4;
  localparam int unsigned DefThresh    = 200;
  localparam int unsigned DefLeakShift = 3;
  localparam int unsigned DefRefract   = 2;
  localparam int unsigned DefCntW      = 16;

  // Unsigned saturate to hi; operands are zero-extended to 32 bits by the caller.
  function automatic logic [31:0] sat_u32(input logic [31:0] v, input logic [31:0] hi);
    return (v > hi) ? hi : v;
  endfunction

  // Clamp a signed value into [0, hi].
  function automatic logic [31:0] clamp_s32(input logic signed [31:0] v,
                                            input logic signed [31:0] hi);
    if (v < 0) begin
      return '0;
    end else if (v > hi) begin
      return hi;
    end
    return v;
  endfunction

endpackage

// File: rtl/lif_neuron.sv
// Single LIF neuron: leak, integrate with saturation, fire at threshold, then refractory.
module lif_neuron
  import lif_pkg::*;
#(
  parameter int unsigned IN_W       = DefInW,
  parameter int unsigned W          = DefW,
  parameter int unsigned THRESH     = DefThresh,
  parameter int unsigned LEAK_SHIFT = DefLeakShift,
  parameter int unsigned REFRACT    = DefRefract
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [IN_W-1:0] current,
  output logic            spike,
  output logic [W-1:0]    state
);

  localparam int unsigned UW = W + IN_W + 1;
  localparam int unsigned RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;
  localparam logic [31:0] VMax = 32'((33'd1 << W) - 33'd1);

  logic [W-1:0]  v_q, v_d;
  logic [RW-1:0] refr_q, refr_d;
  logic          spike_q, spike_d;
  logic [UW-1:0] u_raw;
  logic [W-1:0]  u_sat;
  logic          fire;

  always_comb begin
    u_raw = UW'(v_q) - UW'(v_q >> LEAK_SHIFT) + UW'(current);
    u_sat = W'(sat_u32(32'(u_raw), VMax));
    fire  = (u_sat >= W'(THRESH));
  end

  always_comb begin
    v_d     = v_q;
    refr_d  = refr_q;
    spike_d = spike_q;
    if (ena) begin
      if (refr_q != '0) begin
        refr_d  = refr_q - RW'(1);
        v_d     = '0;
        spike_d = 1'b0;
      end else if (fire) begin
        refr_d  = RW'(REFRACT);
        v_d     = '0;
        spike_d = 1'b1;
      end else begin
        v_d     = u_sat;
        spike_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q     <= '0;
      refr_q  <= '0;
      spike_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      refr_q  <= refr_d;
      spike_q <= spike_d;
    end
  end

  assign spike = spike_q;
  assign state = v_q;

endmodule

// File: rtl/lif_layer_net.sv
// Two-layer LIF network: N_IN input neurons, weighted spike sum, one output neuron
// and a saturating output-spike counter.
module lif_layer_net
  import lif_pkg::*;
#(
  parameter int unsigned N_IN       = 8,
  parameter int unsigned IN_W       = DefInW,
  parameter int unsigned W          = DefW,
  parameter int unsigned WT_W       = DefWtW,
  parameter int unsigned THRESH     = DefThresh,
  parameter int unsigned LEAK_SHIFT = DefLeakShift,
  parameter int unsigned REFRACT    = DefRefract,
  parameter int          WT_RESET   = 1,
  parameter int unsigned CNT_W      = DefCntW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [N_IN*IN_W-1:0]     in_current,
  input  logic                     wr_en,
  input  logic [$clog2(N_IN)-1:0]  wr_addr,
  input  logic [WT_W-1:0]          wr_data,
  output logic [N_IN-1:0]          l1_spikes,
  output logic                     out_spike,
  output logic [W-1:0]             out_state,
  output logic [CNT_W-1:0]         spike_count
);

  localparam int unsigned AW = $clog2(N_IN);
  localparam int unsigned SW = WT_W + AW + 1;
  localparam logic signed [31:0] SumMax = 32'((33'd1 << W) - 33'd1);

  logic signed [WT_W-1:0] wt_q [N_IN];
  logic [W-1:0]           l1_state_unused [N_IN];
  logic signed [SW-1:0]   acc;
  logic [W-1:0]           sum_q, sum_d;
  logic [CNT_W-1:0]       cnt_q;

  for (genvar i = 0; i < N_IN; i++) begin : g_l1
    lif_neuron #(
      .IN_W      (IN_W),
      .W         (W),
      .THRESH    (THRESH),
      .LEAK_SHIFT(LEAK_SHIFT),
      .REFRACT   (REFRACT)
    ) u_neuron (
      .clk    (clk),
      .rst    (rst),
      .ena    (ena),
      .current(in_current[i*IN_W +: IN_W]),
      .spike  (l1_spikes[i]),
      .state  (l1_state_unused[i])
    );
  end

  // Weight writes ignore ena; the summation sees the new value from the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_IN); i++) begin
        wt_q[i] <= WT_W'(WT_RESET);
      end
    end else if (wr_en && (32'(wr_addr) < N_IN)) begin
      wt_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (l1_spikes[i]) begin
        acc = acc + SW'(wt_q[i]);
      end
    end
    sum_d = W'(clamp_s32(32'(acc), SumMax));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (ena) begin
      sum_q <= sum_d;
      if (out_spike && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  lif_neuron #(
    .IN_W      (W),
    .W         (W),
    .THRESH    (THRESH),
    .LEAK_SHIFT(LEAK_SHIFT),
    .REFRACT   (REFRACT)
  ) u_out (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .current(sum_q),
    .spike  (out_spike),
    .state  (out_state)
  );

  // cnt_q lags by one spike; folding in the live spike makes the count move on the
  // same edge as out_spike without a second copy of the neuron's fire logic.
  assign spike_count = (out_spike && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

endmodule

// File: tb/tb_lif_layer_net.sv
// Bench for lif_layer_net: arithmetic network model checked every cycle, plus
// hand-computed directed expectations.
module tb_lif_layer_net;

  localparam int N    = 8;
  localparam int IW   = 8;
  localparam int WTW  = 8;
  localparam int TH   = 200;
  localparam int LS   = 3;
  localparam int RF   = 2;
  localparam int VMAX = 255;
  localparam int N3   = 6;
  localparam int WTW3 = 4;

  logic clk = 1'b0;
  logic rst;
  logic ena;
  logic [N*IW-1:0] cur;
  logic            wr_en;
  logic [2:0]      wr_addr;
  logic [WTW-1:0]  wr_data;
  logic [N-1:0]    l1_spikes;
  logic            out_spike;
  logic [7:0]      out_state;
  logic [15:0]     spike_count;

  logic [N-1:0]    l1_unused2;
  logic            out_spike_unused2;
  logic [7:0]      out_state_unused2;
  logic [1:0]      spike_count2;

  logic [N3*IW-1:0] cur3;
  logic             wr3_en;
  logic [2:0]       wr3_addr;
  logic [WTW3-1:0]  wr3_data;
  logic [N3-1:0]    l1_unused3;
  logic             out_spike_unused3;
  logic [7:0]       out_state3;
  logic [15:0]      count_unused3;

  int total = 0;
  int bad   = 0;

  // Model state: index N is the output neuron.
  int mv [N+1];
  int mr [N+1];
  int ms [N+1];
  int mwt [N];
  int msum;
  int mcnt;

  int pat1 [8] = '{0, 0, 1, 0, 0, 0, 0, 1};
  int exp2 [4] = '{56, 49, 43, 94};

  always #5 clk = ~clk;

  lif_layer_net #(.WT_W(WTW)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .in_current(cur),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .l1_spikes(l1_spikes), .out_spike(out_spike), .out_state(out_state),
    .spike_count(spike_count)
  );

  lif_layer_net #(.WT_W(WTW), .CNT_W(2)) u_dut_cnt2 (
    .clk(clk), .rst(rst), .ena(ena), .in_current(cur),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .l1_spikes(l1_unused2), .out_spike(out_spike_unused2), .out_state(out_state_unused2),
    .spike_count(spike_count2)
  );

  lif_layer_net #(.N_IN(N3)) u_dut_n6 (
    .clk(clk), .rst(rst), .ena(ena), .in_current(cur3),
    .wr_en(wr3_en), .wr_addr(wr3_addr), .wr_data(wr3_data),
    .l1_spikes(l1_unused3), .out_spike(out_spike_unused3), .out_state(out_state3),
    .spike_count(count_unused3)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void nstep(input int v, input int r, input int c,
                                output int nv, output int nr, output int ns);
    int u;
    if (r > 0) begin
      nv = 0; nr = r - 1; ns = 0;
    end else begin
      u = v - (v >> LS) + c;
      if (u > VMAX) u = VMAX;
      if (u >= TH) begin
        nv = 0; nr = RF; ns = 1;
      end else begin
        nv = u; nr = 0; ns = 0;
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= N; i++) begin
      mv[i] = 0; mr[i] = 0; ms[i] = 0;
    end
    for (int i = 0; i < N; i++) mwt[i] = 1;
    msum = 0;
    mcnt = 0;
  endtask

  task automatic model_step();
    int acc, nv, nr, ns;
    if (rst) begin
      model_reset();
    end else begin
      if (ena) begin
        acc = 0;
        for (int i = 0; i < N; i++) if (ms[i] != 0) acc += mwt[i];
        if (acc < 0) acc = 0;
        if (acc > VMAX) acc = VMAX;
        for (int i = 0; i < N; i++) begin
          nstep(mv[i], mr[i], int'(cur[i*IW +: IW]), nv, nr, ns);
          mv[i] = nv; mr[i] = nr; ms[i] = ns;
        end
        nstep(mv[N], mr[N], msum, nv, nr, ns);
        mv[N] = nv; mr[N] = nr; ms[N] = ns;
        if (ms[N] != 0 && mcnt < 65535) mcnt++;
        msum = acc;
      end
      if (wr_en && int'(wr_addr) < N) mwt[wr_addr] = int'($signed(wr_data));
    end
  endtask

  function automatic int l1_exp();
    int r = 0;
    for (int i = 0; i < N; i++) if (ms[i] != 0) r |= (1 << i);
    return r;
  endfunction

  always @(negedge clk) begin
    chk("l1_spikes", int'(l1_spikes), l1_exp());
    chk("out_spike", int'(out_spike), ms[N]);
    chk("out_state", int'(out_state), mv[N]);
    chk("spike_count", int'(spike_count), mcnt);
    chk("spike_count_w2", int'(spike_count2), (mcnt > 3) ? 3 : mcnt);
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_all(input int val);
    ena   = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      wr_addr = 3'(i);
      wr_data = WTW'(val);
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; cur = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    cur3 = '0; wr3_en = 1'b0; wr3_addr = '0; wr3_data = '0;
    model_reset();
    tick();
    tick();
    chk("reset_l1", int'(l1_spikes), 0);
    chk("reset_out_state", int'(out_state), 0);
    chk("reset_count", int'(spike_count), 0);
    chk("reset_count_w2", int'(spike_count2), 0);
    rst = 1'b0;

    // Single neuron driven with 100.
    cur[IW-1:0] = 8'd100;
    ena = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("single_l1_0_edge%0d", k + 1), int'(l1_spikes[0]), pat1[k]);
      chk("single_l1_others", int'(l1_spikes[N-1:1]), 0);
    end

    // All weights 7, all currents full scale.
    ena = 1'b0; cur = '0;
    sync_reset();
    write_all(7);
    cur = {N{8'd255}};
    ena = 1'b1;
    tick();
    chk("w7_l1_all", int'(l1_spikes), 255);
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("w7_out_state_edge%0d", k + 3), int'(out_state), exp2[k]);
    end
    repeat (6) tick();

    // weight[2] <- -3 on the edge that sums the first spike burst.
    ena = 1'b0; cur = '0;
    sync_reset();
    write_all(7);
    cur = {N{8'd255}};
    ena = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'hFD;
    tick();
    wr_en = 1'b0;
    tick();
    chk("wr_old_used_edge3", int'(out_state), 56);
    tick();
    tick();
    tick();
    chk("wr_new_used_edge6", int'(out_state), 84);

    // All weights -8; N_IN=6 instance gets out-of-range writes and weight[2] = -3.
    ena = 1'b0; cur = '0;
    sync_reset();
    wr_en = 1'b1;
    for (int i = 0; i < N; i++) begin
      wr_addr  = 3'(i);
      wr_data  = 8'hF8;
      wr3_en   = (i < 3);
      wr3_addr = (i == 0) ? 3'd6 : (i == 1) ? 3'd7 : 3'd2;
      wr3_data = (i == 2) ? 4'hD : 4'h8;
      tick();
    end
    wr_en = 1'b0; wr3_en = 1'b0;
    cur  = {N{8'd255}};
    cur3 = {N3{8'd255}};
    ena  = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("neg_clamp_out_state", int'(out_state), 0);
      if (k == 3) chk("n6_oob_ignored_edge3", int'(out_state3), 2);
      if (k == 6) chk("n6_oob_ignored_edge6", int'(out_state3), 4);
    end

    // Run, freeze 5 cycles with a write during the hold, then resume.
    ena = 1'b0; cur = '0; cur3 = '0;
    sync_reset();
    write_all(100);
    for (int i = 0; i < N; i++) cur[i*IW +: IW] = 8'(40 + 20 * i);
    ena = 1'b1;
    repeat (10) tick();
    ena = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hCE;
    tick();
    wr_en = 1'b0;
    repeat (4) tick();
    ena = 1'b1;
    repeat (15) tick();

    // Drive the output neuron hard so the 2-bit counter saturates.
    cur = {N{8'd255}};
    repeat (20) tick();
    chk("cnt_w2_saturated", int'(spike_count2), 3);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_l1", int'(l1_spikes), 0);
    chk("async_out_spike", int'(out_spike), 0);
    chk("async_out_state", int'(out_state), 0);
    chk("async_count", int'(spike_count), 0);
    chk("async_count_w2", int'(spike_count2), 0);
    cur = '0;
    cur[IW-1:0] = 8'd100;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("wt_reset_value_edge5", int'(out_state), 1);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lif_layer_net.md
# lif_layer_net

Parametrised successor to the fixed 8-input LIF network. N_IN input leaky-integrate-and-fire neurons take multi-bit currents. Their spikes are combined through programmable signed weights into a registered, clamped current that drives one output LIF neuron. Configurable leak, threshold and refractory period, plus a saturating output-spike counter. Sits between the input switch bus and the display/spike outputs of the top level.

## Interface
Parameters:
- N_IN, 8: number of input neurons (≥2)
- IN_W, 8: input current width per neuron, unsigned
- W, 8: membrane width, unsigned
- WT_W, 4: weight width, two's complement
- THRESH, 200: firing threshold, 1..2^W-1
- LEAK_SHIFT, 3: leak = V >> LEAK_SHIFT, ≥1
- REFRACT, 2: refractory cycles after a spike, ≥0
- WT_RESET, 1: reset value of every weight
- CNT_W, 16: spike counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ena  in  1  advance network; low = hold all neuron/sum/counter state
- in_current  in  N_IN*IN_W  neuron i current at [i*IN_W +: IN_W]
- wr_en  in  1  weight write strobe
- wr_addr  in  $clog2(N_IN)  weight index
- wr_data  in  WT_W  signed weight value
- l1_spikes  out  N_IN  registered input-layer spikes
- out_spike  out  1  registered output-neuron spike
- out_state  out  W  output-neuron membrane
- spike_count  out  CNT_W  output spikes since reset, saturating

## Operation
- Reset (async, rst=1) clears all membranes, refractory counters, spikes, sum register and spike_count to 0. Every weight resets to WT_RESET.
- Neuron update per edge with ena=1, applied to each input neuron with I = in_current slice and to the output neuron with I = sum register:
  - refr>0: refr−1, V stays 0, spike 0.
  - Otherwise compute u = V − (V>>LEAK_SHIFT) + I in W+IN_W+1 bits, saturating at 2^W−1.
  - If u ≥ THRESH: spike←1, V←0, refr←REFRACT. Otherwise V←u, spike←0.
- Summation: acc = Σ weight[i] over i where l1_spikes[i]=1. Signed, width WT_W+$clog2(N_IN)+1. Clamp acc<0 to 0 and acc>2^W−1 to 2^W−1, then register as the W-bit sum.
- Weights: with wr_en=1 and wr_addr<N_IN, weight[wr_addr]←wr_data on the edge. wr_addr≥N_IN is ignored. Writes are honoured regardless of ena. A write takes effect in the summation from the next edge.
- spike_count increments on every edge where out_spike becomes 1, and holds at 2^CNT_W−1.
- ena=0: no state changes except weight writes.

## Timing
- Current presented before edge k: l1 membrane/spike update visible after edge k.
- Sum reflects l1_spikes after edge k+1. The output neuron integrates it at edge k+2.
- Minimum input-to-out_spike latency is 3 edges. spike_count updates on the same edge as out_spike.
- Per neuron, the minimum spike spacing is REFRACT+1 edges. With REFRACT=0, a neuron may fire on consecutive edges.
- Simultaneous weight write and use on the same edge: summation uses the old weight.
- Reset mid-operation clears state immediately, independent of clk. First integration occurs at the first edge after rst deasserts.

## Structure
- Shared package lif_pkg: default constants (THRESH, LEAK_SHIFT, REFRACT, widths) and the saturating-add/clamp functions.
- One sub-module, lif_neuron, parametrised by IN_W, W, THRESH, LEAK_SHIFT, REFRACT, with ports clk, rst, ena, current, spike, state, all registered. It is instantiated N_IN times via generate, plus once for the output neuron with IN_W=W.
- The top holds the weight register file, adder tree, clamp, sum register and counter.

## Test plan
- Single neuron: in_current[0]=100, others 0, defaults. V0 = 100, 188, then spike at edge 3. V0 stays 0 for edges 4–5, integrates 100 at edge 6, spikes again at edge 8.
- All weights written 7, all currents 255. l1_spikes all 1 after edge 1, sum=56 after edge 2. out_state = 56, 49, 43, 94 after edges 3–6.
- All weights written −8, all currents 255. Sum stays 0 and out_state stays 0 indefinitely (negative clamp).
- Write to wr_addr=N_IN with wr_en=1: no weight changes. Write weight[2]=−3 during a spike edge: old weight is used that edge and −3 from the next.
- Hold ena=0 for 5 cycles mid-run: all membranes, sums and spike_count frozen, while a weight write issued during hold still applies. Resuming gives the same sequence shifted by 5 cycles.
- Assert rst asynchronously between edges mid-run: all outputs 0 and weights = WT_RESET immediately. CNT_W=2 override: spike_count saturates at 3.
